ram_loader: RTL and testbench
=============================

# ram_loader

Byte-stream loader and dumper for the instruction and data RAMs. It sits directly upstream of the RAM block on its debug/load path. It takes framed commands from a host byte link (SPI/UART front end, valid/ready), and drives the RAM's loader-side select, address, data and byte-enable inputs. It writes bytes into IRAM/DRAM, and it returns bytes read through the RAM's 8-bit byte read port.

## Interface
- XLEN, 32, address/data width toward RAM
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- rx_data_i  in  8  host byte
- rx_valid_i  in  1  host byte valid
- rx_ready_o  out  1  loader accepts rx byte this cycle
- tx_data_o  out  8  readback byte
- tx_valid_o  out  1  readback byte valid
- tx_ready_i  in  1  host consumes tx byte
- iram_rd_sel_o / iram_wr_sel_o  out  1 each  loader owns IRAM read / write port
- dram_rd_sel_o / dram_wr_sel_o  out  1 each  loader owns DRAM read / write port
- ram_rd_addr_o  out  XLEN  byte address, fans out to both IRAM and DRAM loader read-address inputs
- ram_wr_addr_o  out  XLEN  byte address for writes
- ram_wr_data_o  out  XLEN  write byte replicated to all four lanes
- ram_wr_byte_en_o  out  4  one-hot lane = addr[1:0]
- ram_rd_data_i  in  8  byte selected by RAM from its registered word
- busy_o  out  1  high whenever state != IDLE

## Operation
- Frame: CMD, ADDR[31:24], ADDR[23:16], ADDR[15:8], ADDR[7:0], LEN[15:8], LEN[7:0], then payload. Byte count = LEN+1 (1..65536).
- CMD: 0x2A write IRAM, 0x2B write DRAM, 0x3A read IRAM, 0x3B read DRAM. Any other CMD byte is consumed and dropped, and the FSM stays in IDLE.
- The address is passed raw. RAM decodes the region: IRAM is 0x0000_0000–0x0001_FFFF, and DRAM is 0x0002_0000–0x0003_FFFF. Out-of-region accesses are harmless no-ops, and reads of them return whatever the RAM presents.
- States: IDLE → HDR (6 bytes, shift into addr/len) → WR_DATA or RD_ADDR.
  - Write path: WR_DATA → WR_COMMIT → WR_DATA, or IDLE after the last byte.
  - Read path: RD_ADDR → RD_DATA → RD_SEND → RD_ADDR, or IDLE after the last byte.
- rx_ready_o is high only in IDLE, HDR and WR_DATA.
- WR_COMMIT (one cycle):
  - The selected wr_sel is high, with the addr, replicated data and one-hot byte_en.
  - At the end of the cycle, addr += 1 (wraps modulo 2^32) and the counter decrements.
- RD_ADDR and RD_DATA:
  - The selected rd_sel is high, and ram_rd_addr_o holds the current addr.
  - At the end of RD_DATA, ram_rd_data_i is captured into tx_data_o.
- RD_SEND: tx_valid_o stays high, with tx_data_o stable, until tx_ready_i. On the handshake, addr += 1, the counter decrements, and the FSM leaves RD_SEND.
- At most one of the four sel outputs is ever high. The loader never asserts rd_sel and wr_sel together.
- Reset (any time, including mid-frame or mid-read): FSM to IDLE.
  - All sel, valid and byte_en outputs go to 0. addr, len, counter, tx_data_o and ram_*_addr/data go to 0. rx_ready_o goes to 0 while rst_i is high.
  - A partially received frame is discarded.

## Timing
- rx handshake: a byte transfers on a rising edge where rx_valid_i && rx_ready_o.
- Header: 7 accepted bytes, one per cycle maximum.
- Write throughput: 1 byte per 2 cycles. The RAM write occurs on the edge ending WR_COMMIT, which is the cycle after the byte is accepted.
- Read latency: the first tx_valid_o rises 3 cycles after the edge accepting LEN[7:0] (IDLE→…→RD_ADDR→RD_DATA→RD_SEND). Steady state is 3 cycles per byte with tx_ready_i held high.
- The RAM read port is synchronous with 1-cycle latency. The address is held across RD_ADDR and RD_DATA so the RAM's byte-lane mux uses the correct addr[1:0].
- The last byte (counter == 0) returns to IDLE on the same edge that would otherwise advance. busy_o falls on that edge.

## Structure
- Package ram_loader_pkg holds:
  - the state enum: IDLE, HDR, WR_DATA, WR_COMMIT, RD_ADDR, RD_DATA, RD_SEND;
  - CMD constants 0x2A, 0x2B, 0x3A, 0x3B;
  - a header-length constant of 6.
- A single flat module with no sub-module. The header shift register, address counter and byte counter live inline.

## Test plan
- Write IRAM: frame 2A 00 00 00 01 00 02 with payload AA BB CC. Expect three WR_COMMIT pulses:
  - iram_wr_sel_o=1, addr 0x1/0x2/0x3, byte_en 0010/0100/1000, data 0xAAAAAAAA/0xBBBBBBBB/0xCCCCCCCC;
  - busy_o falls after the third pulse.
- Read DRAM: frame 3B 00 02 00 00 00 03, with the RAM model preloaded 0x44332211 at 0x20000. Expect:
  - dram_rd_sel_o only, ram_rd_addr_o 0x20000..0x20003;
  - tx bytes 11 22 33 44;
  - first tx_valid_o 3 cycles after the LEN byte.
- tx backpressure: during the read, hold tx_ready_i low for 10 cycles. Expect tx_valid_o and tx_data_o stable, ram_rd_addr_o unchanged, and no byte lost or duplicated.
- Invalid command and wrap: byte 0x55 followed by frame 2A FF FF FF FF 00 01 with payload 01 02. Expect:
  - 0x55 dropped, with no sel asserted;
  - writes at 0xFFFFFFFF then 0x00000000 (byte_en 1000 then 0001).
- Reset mid-operation: assert rst_i during the RD_SEND of byte 2 of 4. Expect all outputs 0 asynchronously and busy_o=0. A following 2A frame executes correctly from IDLE.
- rx stall: insert rx_valid_i gaps inside the header and payload. Expect identical RAM writes. rx_ready_o must be low in every WR_COMMIT cycle.

Source files
------------

// File: rtl/ram_loader_pkg.sv
`default_nettype none
// ============================================================================
// ram_loader_pkg : FSM states, host command codes and header length shared by
//                  the RAM byte loader and anything that talks to it.
// Revision       : 1.0
// ============================================================================
package ram_loader_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      HDR       = 3'd1,
      WR_DATA   = 3'd2,
      WR_COMMIT = 3'd3,
      RD_ADDR   = 3'd4,
      RD_DATA   = 3'd5,
      RD_SEND   = 3'd6
   } state_t;

   localparam logic [7:0] C_CMD_WR_IRAM = 8'h2A;
   localparam logic [7:0] C_CMD_WR_DRAM = 8'h2B;
   localparam logic [7:0] C_CMD_RD_IRAM = 8'h3A;
   localparam logic [7:0] C_CMD_RD_DRAM = 8'h3B;

   // Address (4 bytes) plus length (2 bytes) following the command byte.
   localparam logic [2:0] C_HDR_LEN = 3'd6;

   function automatic logic is_valid_cmd(input logic [7:0] b);
      return (b == C_CMD_WR_IRAM) || (b == C_CMD_WR_DRAM) ||
             (b == C_CMD_RD_IRAM) || (b == C_CMD_RD_DRAM);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ram_loader.sv
`default_nettype none
// ============================================================================
// ram_loader : framed host byte stream -> IRAM/DRAM loader port writes and
//              byte readback through the RAM's 8-bit read port.
// Revision   : 1.0
// ============================================================================
module ram_loader
   import ram_loader_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [7:0]      rx_data_i,
   input  logic            rx_valid_i,
   output logic            rx_ready_o,
   output logic [7:0]      tx_data_o,
   output logic            tx_valid_o,
   input  logic            tx_ready_i,
   output logic            iram_rd_sel_o,
   output logic            iram_wr_sel_o,
   output logic            dram_rd_sel_o,
   output logic            dram_wr_sel_o,
   output logic [XLEN-1:0] ram_rd_addr_o,
   output logic [XLEN-1:0] ram_wr_addr_o,
   output logic [XLEN-1:0] ram_wr_data_o,
   output logic [3:0]      ram_wr_byte_en_o,
   input  logic [7:0]      ram_rd_data_i,
   output logic            busy_o
);

   state_t           r_state;
   logic [XLEN-1:0]  r_addr;
   logic [15:0]      r_len;
   logic [15:0]      r_cnt;
   logic [2:0]       r_hdr_cnt;
   logic             r_is_read;
   logic             r_is_dram;

   logic             w_rx_fire;
   logic             w_tx_fire;
   logic             w_last;
   logic [XLEN+15:0] w_hdr_next;
   logic [XLEN-1:0]  w_addr_inc;

   assign w_rx_fire  = rx_valid_i && rx_ready_o;
   assign w_tx_fire  = tx_valid_o && tx_ready_i;
   assign w_last     = (r_cnt == 16'd0);
   // Address and length form one shift register; the final header byte
   // completes both, so the look-ahead value seeds the first access.
   assign w_hdr_next = {r_addr[XLEN-9:0], r_len, rx_data_i};
   assign w_addr_inc = r_addr + 1'b1;
   assign busy_o     = (r_state != IDLE);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state          <= IDLE;
         r_addr           <= '0;
         r_len            <= '0;
         r_cnt            <= '0;
         r_hdr_cnt        <= '0;
         r_is_read        <= 1'b0;
         r_is_dram        <= 1'b0;
         rx_ready_o       <= 1'b0;
         tx_data_o        <= '0;
         tx_valid_o       <= 1'b0;
         iram_rd_sel_o    <= 1'b0;
         iram_wr_sel_o    <= 1'b0;
         dram_rd_sel_o    <= 1'b0;
         dram_wr_sel_o    <= 1'b0;
         ram_rd_addr_o    <= '0;
         ram_wr_addr_o    <= '0;
         ram_wr_data_o    <= '0;
         ram_wr_byte_en_o <= '0;
      end else begin
         iram_wr_sel_o    <= 1'b0;
         dram_wr_sel_o    <= 1'b0;
         ram_wr_byte_en_o <= '0;
         case (r_state)
            IDLE: begin
               rx_ready_o <= 1'b1;
               if (w_rx_fire && is_valid_cmd(rx_data_i)) begin
                  r_state   <= HDR;
                  r_hdr_cnt <= '0;
                  r_is_read <= (rx_data_i == C_CMD_RD_IRAM) || (rx_data_i == C_CMD_RD_DRAM);
                  r_is_dram <= (rx_data_i == C_CMD_WR_DRAM) || (rx_data_i == C_CMD_RD_DRAM);
               end
            end
            HDR: begin
               if (w_rx_fire) begin
                  {r_addr, r_len} <= w_hdr_next;
                  r_hdr_cnt       <= r_hdr_cnt + 3'd1;
                  if (r_hdr_cnt == C_HDR_LEN - 3'd1) begin
                     r_cnt <= w_hdr_next[15:0];
                     if (r_is_read) begin
                        r_state       <= RD_ADDR;
                        rx_ready_o    <= 1'b0;
                        iram_rd_sel_o <= !r_is_dram;
                        dram_rd_sel_o <= r_is_dram;
                        ram_rd_addr_o <= w_hdr_next[XLEN+15:16];
                     end else begin
                        r_state <= WR_DATA;
                     end
                  end
               end
            end
            WR_DATA: begin
               if (w_rx_fire) begin
                  r_state          <= WR_COMMIT;
                  rx_ready_o       <= 1'b0;
                  iram_wr_sel_o    <= !r_is_dram;
                  dram_wr_sel_o    <= r_is_dram;
                  ram_wr_addr_o    <= r_addr;
                  ram_wr_data_o    <= {(XLEN/8){rx_data_i}};
                  ram_wr_byte_en_o <= 4'b0001 << r_addr[1:0];
               end
            end
            WR_COMMIT: begin
               r_addr     <= w_addr_inc;
               rx_ready_o <= 1'b1;
               if (w_last) begin
                  r_state <= IDLE;
               end else begin
                  r_cnt   <= r_cnt - 16'd1;
                  r_state <= WR_DATA;
               end
            end
            RD_ADDR: begin
               r_state <= RD_DATA;
            end
            RD_DATA: begin
               r_state       <= RD_SEND;
               iram_rd_sel_o <= 1'b0;
               dram_rd_sel_o <= 1'b0;
               tx_data_o     <= ram_rd_data_i;
               tx_valid_o    <= 1'b1;
            end
            RD_SEND: begin
               if (w_tx_fire) begin
                  tx_valid_o <= 1'b0;
                  r_addr     <= w_addr_inc;
                  if (w_last) begin
                     r_state    <= IDLE;
                     rx_ready_o <= 1'b1;
                  end else begin
                     r_cnt         <= r_cnt - 16'd1;
                     r_state       <= RD_ADDR;
                     iram_rd_sel_o <= !r_is_dram;
                     dram_rd_sel_o <= r_is_dram;
                     ram_rd_addr_o <= w_addr_inc;
                  end
               end
            end
            default: begin
               r_state    <= IDLE;
               rx_ready_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ram_loader.sv
`default_nettype none
// ============================================================================
// tb_ram_loader : self-checking bench for ram_loader with a RAM model and a
//                 byte-level reference memory.
// Revision      : 1.0
// ============================================================================
module tb_ram_loader;
   import ram_loader_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        iram_rd_sel, iram_wr_sel, dram_rd_sel, dram_wr_sel;
   logic [31:0] rd_addr, wr_addr, wr_data;
   logic [3:0]  wr_be;
   logic [7:0]  rd_data;
   logic        busy;

   always #5 clk = ~clk;

   ram_loader #(.XLEN(32)) dut (
      .clk_i(clk), .rst_i(rst),
      .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
      .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
      .iram_rd_sel_o(iram_rd_sel), .iram_wr_sel_o(iram_wr_sel),
      .dram_rd_sel_o(dram_rd_sel), .dram_wr_sel_o(dram_wr_sel),
      .ram_rd_addr_o(rd_addr), .ram_wr_addr_o(wr_addr),
      .ram_wr_data_o(wr_data), .ram_wr_byte_en_o(wr_be),
      .ram_rd_data_i(rd_data), .busy_o(busy)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic bit in_iram(input logic [31:0] a);
      return a < 32'h0002_0000;
   endfunction
   function automatic bit in_dram(input logic [31:0] a);
      return (a >= 32'h0002_0000) && (a < 32'h0004_0000);
   endfunction
   function automatic bit region_ok(input bit dram, input logic [31:0] a);
      return dram ? in_dram(a) : in_iram(a);
   endfunction

   // RAM block model: byte-lane writes, registered word read, lane mux on addr[1:0]
   logic [7:0]  ram_mem [logic [31:0]];
   logic [31:0] rd_word = '0;

   function automatic logic [7:0] ram_get(input logic [31:0] a);
      return ram_mem.exists(a) ? ram_mem[a] : 8'h00;
   endfunction

   always @(posedge clk) begin
      if ((iram_wr_sel && in_iram(wr_addr)) || (dram_wr_sel && in_dram(wr_addr)))
         for (int l = 0; l < 4; l++)
            if (wr_be[l]) ram_mem[{wr_addr[31:2], 2'(l)}] = wr_data[8*l +: 8];
      if ((iram_rd_sel && in_iram(rd_addr)) || (dram_rd_sel && in_dram(rd_addr)))
         rd_word <= {ram_get({rd_addr[31:2], 2'd3}), ram_get({rd_addr[31:2], 2'd2}),
                     ram_get({rd_addr[31:2], 2'd1}), ram_get({rd_addr[31:2], 2'd0})};
      else if (iram_rd_sel || dram_rd_sel)
         rd_word <= '0;
   end
   assign rd_data = rd_word[8*rd_addr[1:0] +: 8];

   // Reference memory: what the host believes has been written
   logic [7:0] ref_mem [logic [31:0]];
   function automatic logic [7:0] ref_get(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   // Monitors sampled mid-cycle
   typedef struct packed {
      logic        dram;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } wr_t;
   wr_t         wq[$];
   logic [7:0]  txq[$];
   logic [32:0] rq[$];
   logic        prev_rd = 1'b0;

   always @(negedge clk) begin
      if (!rst) begin
         if (iram_wr_sel || dram_wr_sel) begin
            wq.push_back({dram_wr_sel, wr_addr, wr_data, wr_be});
            check("rx_ready_in_commit", rx_ready, 1'b0);
         end
         if (tx_valid && tx_ready) txq.push_back(tx_data);
         if ((iram_rd_sel || dram_rd_sel) && !prev_rd) rq.push_back({dram_rd_sel, rd_addr});
         if (iram_rd_sel || dram_rd_sel || iram_wr_sel || dram_wr_sel)
            check("sel_onehot", $countones({iram_rd_sel, dram_rd_sel, iram_wr_sel, dram_wr_sel}), 1);
      end
      prev_rd <= iram_rd_sel || dram_rd_sel;
   end

   // Stimulus helpers: every task starts and ends 1 time unit after a rising edge
   task automatic send_byte(input logic [7:0] b, input int gap);
      int budget;
      repeat (gap) begin @(posedge clk); #1; end
      rx_valid = 1'b1;
      rx_data  = b;
      budget   = 0;
      while (!rx_ready && budget < 200) begin @(posedge clk); #1; budget++; end
      if (budget >= 200) check("rx_accept_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a,
                             input logic [15:0] len, input int maxgap);
      send_byte(cmd, $urandom_range(0, maxgap));
      for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8], $urandom_range(0, maxgap));
      send_byte(len[15:8], $urandom_range(0, maxgap));
      send_byte(len[7:0], $urandom_range(0, maxgap));
   endtask

   task automatic wait_idle(input string name);
      int budget = 0;
      while (busy && budget < 2000) begin @(posedge clk); #1; budget++; end
      check(name, busy, 1'b0);
   endtask

   task automatic do_write(input logic [7:0] cmd, input logic [31:0] a,
                           input logic [7:0] pl[$], input int maxgap, input bit chk_tail);
      logic        dram;
      logic [31:0] ea;
      wr_t         w;
      int          n;
      dram = (cmd == C_CMD_WR_DRAM);
      n    = pl.size();
      wq.delete();
      send_frame(cmd, a, 16'(n - 1), maxgap);
      for (int i = 0; i < n; i++) send_byte(pl[i], $urandom_range(0, maxgap));
      if (chk_tail) begin
         check("tail_commit_sel", {iram_wr_sel, dram_wr_sel, busy, rx_ready}, {!dram, dram, 1'b1, 1'b0});
         @(posedge clk); #1;
         check("tail_busy_fall", {busy, iram_wr_sel, dram_wr_sel}, 3'b000);
      end
      wait_idle("wr_done");
      check("wr_count", wq.size(), n);
      for (int i = 0; i < n && wq.size() > 0; i++) begin
         w  = wq.pop_front();
         ea = a + 32'(i);
         check("wr_sel_dram", w.dram, dram);
         check("wr_addr", w.addr, ea);
         check("wr_data", w.data, {4{pl[i]}});
         check("wr_be", w.be, 4'b0001 << ea[1:0]);
         if (region_ok(dram, ea)) ref_mem[ea] = pl[i];
      end
   endtask

   // mode 0: tx_ready high, 1: random tx_ready, 2: first byte held off 10 cycles
   task automatic do_read(input logic [7:0] cmd, input logic [31:0] a, input int n,
                          input int mode, input int maxgap, input bit chk_lat);
      logic        dram;
      logic [31:0] ea;
      logic [7:0]  eb;
      int          budget;
      dram = (cmd == C_CMD_RD_DRAM);
      txq.delete();
      rq.delete();
      tx_ready = 1'b0;
      send_frame(cmd, a, 16'(n - 1), maxgap);
      if (chk_lat) begin
         check("rd_sel_first", {iram_rd_sel, dram_rd_sel, rx_ready}, {!dram, dram, 1'b0});
         check("lat_cycle1", tx_valid, 1'b0);
         @(posedge clk); #1;
         check("lat_cycle2", tx_valid, 1'b0);
         @(posedge clk); #1;
         check("lat_cycle3", tx_valid, 1'b1);
      end
      if (mode == 2) begin
         budget = 0;
         while (!tx_valid && budget < 50) begin @(posedge clk); #1; budget++; end
         eb = region_ok(dram, a) ? ref_get(a) : 8'h00;
         for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("bp_hold", {tx_valid, tx_data, rd_addr}, {1'b1, eb, a});
         end
      end
      budget = 0;
      while (busy && budget < 2000) begin
         tx_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk); #1;
         budget++;
      end
      tx_ready = 1'b0;
      check("rd_done", busy, 1'b0);
      check("rd_count", txq.size(), n);
      check("rd_addr_count", rq.size(), n);
      for (int i = 0; i < n; i++) begin
         ea = a + 32'(i);
         eb = region_ok(dram, ea) ? ref_get(ea) : 8'h00;
         if (i < txq.size()) check("rd_byte", txq[i], eb);
         if (i < rq.size())  check("rd_addr", rq[i], {dram, ea});
      end
   endtask

   typedef struct {
      logic [7:0]  cmd;
      logic [31:0] addr;
      logic [7:0]  data;
      logic        exp_dram;
      logic [3:0]  exp_be;
   } vec_t;

   initial begin
      vec_t        vt[4];
      logic [7:0]  pl[$];
      logic [31:0] a;
      logic [7:0]  cmd;
      wr_t         w;

      vt[0] = '{8'h2A, 32'h0000_0010, 8'h5A, 1'b0, 4'b0001};
      vt[1] = '{8'h2B, 32'h0002_0005, 8'hC3, 1'b1, 4'b0010};
      vt[2] = '{8'h2A, 32'h0001_FFFE, 8'h7E, 1'b0, 4'b0100};
      vt[3] = '{8'h2B, 32'h0003_FFFF, 8'h81, 1'b1, 4'b1000};

      rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
      repeat (2) @(posedge clk); #1;
      check("reset_outputs", {rx_ready, tx_valid, tx_data, iram_rd_sel, iram_wr_sel, dram_rd_sel,
                              dram_wr_sel, wr_be, busy}, '0);
      check("reset_addr_data", {rd_addr, wr_addr}, '0);
      check("reset_wr_data", wr_data, '0);
      #3 rst = 1'b0;
      @(posedge clk); #1;
      check("idle_rx_ready", {rx_ready, busy}, 2'b10);

      // Single-byte writes from a vector table
      for (int i = 0; i < 4; i++) begin
         wq.delete();
         send_frame(vt[i].cmd, vt[i].addr, 16'h0000, 0);
         send_byte(vt[i].data, 0);
         wait_idle("vec_done");
         check("vec_count", wq.size(), 1);
         if (wq.size() > 0) begin
            w = wq.pop_front();
            check("vec_sel", w.dram, vt[i].exp_dram);
            check("vec_addr", w.addr, vt[i].addr);
            check("vec_data", w.data, {4{vt[i].data}});
            check("vec_be", w.be, vt[i].exp_be);
            ref_mem[vt[i].addr] = vt[i].data;
         end
      end

      // IRAM burst with end-of-frame busy check
      pl = '{8'hAA, 8'hBB, 8'hCC};
      do_write(C_CMD_WR_IRAM, 32'h0000_0001, pl, 0, 1'b1);

      // DRAM read of a preloaded word, latency checked
      for (int i = 0; i < 4; i++) begin
         ram_mem[32'h0002_0000 + 32'(i)] = 8'(8'h11 * (i + 1));
         ref_mem[32'h0002_0000 + 32'(i)] = 8'(8'h11 * (i + 1));
      end
      do_read(C_CMD_RD_DRAM, 32'h0002_0000, 4, 0, 0, 1'b1);
      do_read(C_CMD_RD_DRAM, 32'h0002_0000, 4, 2, 0, 1'b0);

      // Unknown command then address wrap
      wq.delete();
      send_byte(8'h55, 0);
      @(posedge clk); #1;
      check("bad_cmd_idle", {busy, iram_wr_sel, dram_wr_sel, iram_rd_sel, dram_rd_sel}, '0);
      check("bad_cmd_no_write", wq.size(), 0);
      pl = '{8'h01, 8'h02};
      do_write(C_CMD_WR_IRAM, 32'hFFFF_FFFF, pl, 0, 1'b0);

      // Reset during the second byte of a four-byte read
      for (int i = 0; i < 4; i++) begin
         ram_mem[32'h0002_0010 + 32'(i)] = 8'hA1 + 8'(i);
         ref_mem[32'h0002_0010 + 32'(i)] = 8'hA1 + 8'(i);
      end
      txq.delete();
      tx_ready = 1'b0;
      send_frame(C_CMD_RD_DRAM, 32'h0002_0010, 16'd3, 0);
      for (int k = 0; k < 2; k++) begin
         for (int b = 0; b < 20 && !tx_valid; b++) begin @(posedge clk); #1; end
         if (k == 0) begin
            tx_ready = 1'b1;
            @(posedge clk); #1;
            tx_ready = 1'b0;
         end
      end
      check("pre_reset_byte1", (txq.size() > 0) ? txq[0] : 8'h00, 8'hA1);
      check("pre_reset_send2", {tx_valid, tx_data}, {1'b1, 8'hA2});
      #2 rst = 1'b1;
      #1;
      check("async_reset_outputs", {rx_ready, tx_valid, tx_data, iram_rd_sel, iram_wr_sel,
                                    dram_rd_sel, dram_wr_sel, wr_be, busy}, '0);
      check("async_reset_addr", {rd_addr, wr_addr}, '0);
      #10 rst = 1'b0;
      @(posedge clk); #1;
      txq.delete();
      pl = '{8'h3C, 8'h4D};
      do_write(C_CMD_WR_IRAM, 32'h0000_0102, pl, 0, 1'b0);

      // Same burst as before with rx gaps everywhere
      pl = '{8'hAA, 8'hBB, 8'hCC};
      do_write(C_CMD_WR_IRAM, 32'h0000_0001, pl, 3, 1'b0);

      // Random traffic against the reference memory
      for (int t = 0; t < 40; t++) begin
         bit dram_r;
         int n;
         dram_r = 1'($urandom_range(0, 1));
         a      = (dram_r ? 32'h0002_0000 : 32'h0) + 32'($urandom_range(0, 63));
         n      = $urandom_range(1, 8);
         if ($urandom_range(0, 1) == 0) begin
            cmd = dram_r ? C_CMD_WR_DRAM : C_CMD_WR_IRAM;
            pl.delete();
            for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
            do_write(cmd, a, pl, $urandom_range(0, 2), 1'b0);
         end else begin
            cmd = dram_r ? C_CMD_RD_DRAM : C_CMD_RD_IRAM;
            do_read(cmd, a, n, 1, $urandom_range(0, 2), 1'b0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
